// File: rtl/diff_demo_pkg.sv
// rtl/diff_demo_pkg.sv - shared widths and state encoding for the psum accumulator
package diff_demo_pkg;

  localparam int PSUM_WIDTH        = 24;
  localparam int ACC_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_HOLD
  } acc_state_e;

endpackage

// File: rtl/sat_lane_add.sv
// rtl/sat_lane_add.sv - unsigned saturating adder for one accumulator lane
module sat_lane_add #(
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [ACC_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  logic [ACC_WIDTH:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[ACC_WIDTH];
  assign o_sum  = o_ovf ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];

endmodule

// File: rtl/psum_unpack_acc.sv
// rtl/psum_unpack_acc.sv - splits packed psums into lanes and accumulates them per group
module psum_unpack_acc #(
  parameter int PSUM_WIDTH = diff_demo_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH  = diff_demo_pkg::ACC_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [PSUM_WIDTH-1:0] in_psum,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [ACC_WIDTH-1:0]  out_acc_hi,
  output logic [ACC_WIDTH-1:0]  out_acc_lo,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_ovf,
  output logic                  err_mode
);

  import diff_demo_pkg::*;

  localparam int HALF = PSUM_WIDTH / 2;

  acc_state_e            r_state, w_next;
  logic [ACC_WIDTH-1:0]  r_acc_hi, r_acc_lo;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ovf, r_grp_mode, r_err_mode;
  logic                  w_in_ready, w_out_valid, w_in_fire, w_first, w_mode;
  logic [ACC_WIDTH-1:0]  w_lane_hi, w_lane_lo, w_base_hi, w_base_lo, w_sum_hi, w_sum_lo;
  logic                  w_ovf_hi, w_ovf_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    case (r_state)
      ACC_IDLE: if (in_valid) w_next = in_last ? ACC_HOLD : ACC_RUN;
      ACC_RUN:  if (in_valid && in_last) w_next = ACC_HOLD;
      ACC_HOLD: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        if (out_ready) w_next = ACC_IDLE;
      end
      default:  w_next = ACC_IDLE;
    endcase
  end

  // The first beat of a group decides the lane split and overwrites stale sums.
  assign w_in_fire = in_valid && w_in_ready;
  assign w_first   = (r_state == ACC_IDLE);
  assign w_mode    = w_first ? in_mode : r_grp_mode;
  assign w_lane_lo = w_mode ? ACC_WIDTH'(in_psum[HALF-1:0]) : ACC_WIDTH'(in_psum);
  assign w_lane_hi = w_mode ? ACC_WIDTH'(in_psum[PSUM_WIDTH-1:HALF]) : '0;
  assign w_base_hi = w_first ? '0 : r_acc_hi;
  assign w_base_lo = w_first ? '0 : r_acc_lo;

  sat_lane_add #(.ACC_WIDTH(ACC_WIDTH)) u_add_hi (
    .i_a(w_base_hi), .i_b(w_lane_hi), .o_sum(w_sum_hi), .o_ovf(w_ovf_hi)
  );

  sat_lane_add #(.ACC_WIDTH(ACC_WIDTH)) u_add_lo (
    .i_a(w_base_lo), .i_b(w_lane_lo), .o_sum(w_sum_lo), .o_ovf(w_ovf_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_grp_mode <= 1'b0;
      r_err_mode <= 1'b0;
    end else if (w_in_fire) begin
      r_acc_hi   <= w_sum_hi;
      r_acc_lo   <= w_sum_lo;
      r_grp_mode <= w_mode;
      r_ovf      <= (w_first ? 1'b0 : r_ovf) | w_ovf_hi | w_ovf_lo;
      if (w_first)             r_cnt <= CNT_WIDTH'(1);
      else if (r_cnt != '1)    r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (!w_first && (in_mode != r_grp_mode)) r_err_mode <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_mode   = r_grp_mode;
  assign out_acc_hi = r_acc_hi;
  assign out_acc_lo = r_acc_lo;
  assign out_cnt    = r_cnt;
  assign out_ovf    = r_ovf;
  assign err_mode   = r_err_mode;

endmodule
